alu_seq: RTL
============

Name: alu_seq

Overview:
- Iterative multiply/divide sequencer that initiates operations on the 16-bit datapath ALU/shifter.
- Owns the T (high/remainder) and N (low/quotient) working registers and drives the ALU's op_alu/op_shf/t/aopy/carry/n15/n0 inputs each cycle.
- Captures rshf/cf/arez0 back into T and N.
- Sits between the CPU execute stage (start/done handshake) and the ALU instance.

Parameters:
- WIDTH, 16, operand width; fixed by the ALU interface, not overridable in this revision.
- STEPS, 16, iterations per multiply/divide; must equal WIDTH.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- cmd  in  1  0 = unsigned multiply, 1 = unsigned divide.
- opa  in  16  multiplicand / dividend.
- opb  in  16  multiplier / divisor.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- res_hi  out  16  product[31:16] / remainder.
- res_lo  out  16  product[15:0] / quotient.
- dz  out  1  divide-by-zero flag; valid with done, held until next accept.
- op_alu  out  4  ALU operation select.
- op_shf  out  4  shifter select.
- t  out  16  ALU X operand (T register).
- aopy  out  16  ALU Y operand (M register).
- carry  out  1  ALU carry-in source; always 0.
- n15  out  1  N[15].
- n0  out  1  N[0].
- rshf  in  17  shifter result.
- cf  in  1  ALU carry out.
- arez0  in  1  ALU result bit 0.

Behaviour:
- Reset:
  - State = IDLE; T, N, M, res_hi, res_lo = 0.
  - busy, done, dz = 0; op_alu = op_shf = 4'b0000.
- ALU encodings used:
  - 4'b0000 = pass T (cf = carry = 0).
  - 4'b1000 = T+M (cf = carry out).
  - 4'b0100 = T-M (cf = 1 means no borrow).
  - Shifter 4'b0000 gives {cf, arez}.
  - Shifter 4'b1010 gives {arez, n15}.
  - Shifter 4'b1101 gives {n0, cf, arez[15:1]}.
- IDLE: start=1 loads M=opb and T=0.
  - Multiply: N=opa.
  - Divide: N=opa, step counter = 0.
  - busy rises the next cycle.
  - Next state: MUL, DIV_SH, or DZ when cmd=1 and opb=0.
- MUL (16 cycles):
  - op_alu = N[0] ? 4'b1000 : 4'b0000; op_shf = 4'b1101.
  - Register update: T <= rshf[15:0]; N <= {arez0, N[15:1]}.
  - After 16 steps go to FIN.
- DIV_SH (1 cycle per step):
  - op_alu = 4'b0000; op_shf = 4'b1010.
  - Register update: ovf <= rshf[16]; T <= rshf[15:0]; N <= {N[14:0], 1'b0}.
  - Next state: DIV_SUB.
- DIV_SUB (1 cycle per step):
  - op_alu = 4'b0100; op_shf = 4'b0000.
  - If ovf or rshf[16]: T <= rshf[15:0] and N[0] <= 1. Otherwise T and N hold.
  - After 16 SH/SUB pairs go to FIN; otherwise go to DIV_SH.
- DZ (1 cycle): res_hi = opa (the N value), res_lo = 16'hFFFF, dz = 1; next state FIN.
- FIN (1 cycle):
  - res_hi <= T, res_lo <= N (except after DZ); done = 1; busy = 0.
  - Return to IDLE.
- Latency (start accepted → done): multiply 18 cycles, divide 34, divide-by-zero 3.
- start while not IDLE is ignored, with no queueing. The earliest new accept is the cycle after done.
- res_hi/res_lo/dz are updated only in FIN/DZ; they hold between operations.
- dz clears on the next accept.
- Outside MUL/DIV states, op_alu = op_shf = 4'b0000, with t = T and aopy = M.
- Reset asserted mid-operation aborts immediately to reset values; no done pulse.

Optional Feature:
- Macro ALU_SEQ_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 in any non-IDLE state returns to IDLE on the next edge.
  - busy drops, no done, res_hi/res_lo/dz unchanged.
  - abort in IDLE has no effect and takes priority over start in the same cycle.
- When undefined: no port; every accepted operation runs to completion.

Test Plan:
- Multiply: opa=16'h1234, opb=16'h5678 → done at cycle 18; {res_hi,res_lo}=32'h0626_0060; dz=0.
- Multiply: opa=opb=16'hFFFF → res_hi=16'hFFFE, res_lo=16'h0001; confirms carry into T[15] via cf.
- Divide: opa=16'd1000, opb=16'd7 → done at cycle 34; res_lo=16'd142, res_hi=16'd6.
- Divide: opa=16'hFFFF, opb=16'h8001 → res_lo=1, res_hi=16'h7FFE.
  - Exercises the ovf path.
  - Then opa=16'h0055, opb=0 → done at cycle 3, dz=1, res_lo=16'hFFFF, res_hi=16'h0055.
- start held high through a multiply: the second accept occurs only in the cycle after done. rst_n pulsed low at step 8 → busy=0, outputs at reset values, no done.
- With ALU_SEQ_ABORT_EN: abort at divide step 5 → busy=0 next cycle, no done, res_hi/res_lo keep the prior multiply result.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: iterative 16x16 unsigned multiply/divide sequencer driving the datapath ALU/shifter.
// Define ALU_SEQ_ABORT_EN to add an abort input that cancels an operation in flight.
module alu_seq #(
  localparam int WIDTH = 16,
  localparam int STEPS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmd,
`ifdef ALU_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             dz,
  output logic [3:0]       op_alu,
  output logic [3:0]       op_shf,
  output logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] aopy,
  output logic             carry,
  output logic             n15,
  output logic             n0,
  input  logic [WIDTH:0]   rshf,
  input  logic             cf,
  input  logic             arez0
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV_SH,
    S_DIV_SUB,
    S_DZ,
    S_FIN
  } state_t;

  localparam logic [3:0] ALU_PASS  = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b1000;
  localparam logic [3:0] ALU_SUB   = 4'b0100;
  localparam logic [3:0] SHF_CARRY = 4'b0000;
  localparam logic [3:0] SHF_LEFT  = 4'b1010;
  localparam logic [3:0] SHF_RIGHT = 4'b1101;
  localparam logic [3:0] LAST_STEP = 4'(STEPS - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_t;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_resHi;
  logic [WIDTH-1:0] r_resLo;
  logic [3:0]       r_step;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;

  logic [3:0]       w_opAlu;
  logic [3:0]       w_opShf;
  logic             w_abort;
  logic             w_lastStep;
  logic             w_unusedCf;

  // The shifter already folds the carry into rshf, so cf itself is never consulted.
  assign w_unusedCf = cf;

`ifdef ALU_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_lastStep = (r_step == LAST_STEP);

  // ALU controls must track the live N[0] each multiply step, so they decode from current state.
  always_comb begin
    w_opAlu = ALU_PASS;
    w_opShf = SHF_CARRY;
    case (r_state)
      S_MUL: begin
        w_opAlu = r_n[0] ? ALU_ADD : ALU_PASS;
        w_opShf = SHF_RIGHT;
      end
      S_DIV_SH: begin
        w_opAlu = ALU_PASS;
        w_opShf = SHF_LEFT;
      end
      S_DIV_SUB: begin
        w_opAlu = ALU_SUB;
        w_opShf = SHF_CARRY;
      end
      default: begin
        w_opAlu = ALU_PASS;
        w_opShf = SHF_CARRY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_n     <= '0;
      r_m     <= '0;
      r_resHi <= '0;
      r_resLo <= '0;
      r_step  <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            // The done cycle itself is not an accept slot; the next request lands one cycle later.
            if (start && !r_done && !w_abort) begin
              r_m    <= opb;
              r_t    <= '0;
              r_n    <= opa;
              r_step <= '0;
              r_ovf  <= 1'b0;
              r_dz   <= 1'b0;
              r_busy <= 1'b1;
              if (!cmd) begin
                r_state <= S_MUL;
              end else if (opb == '0) begin
                r_state <= S_DZ;
              end else begin
                r_state <= S_DIV_SH;
              end
            end
          end
          S_MUL: begin
            r_t    <= rshf[WIDTH-1:0];
            r_n    <= {arez0, r_n[WIDTH-1:1]};
            r_step <= r_step + 4'd1;
            if (w_lastStep) begin
              r_state <= S_FIN;
            end
          end
          S_DIV_SH: begin
            r_ovf   <= rshf[WIDTH];
            r_t     <= rshf[WIDTH-1:0];
            r_n     <= {r_n[WIDTH-2:0], 1'b0};
            r_state <= S_DIV_SUB;
          end
          S_DIV_SUB: begin
            // A bit shifted out of T means the 17-bit remainder exceeds M regardless of the borrow.
            if (r_ovf || rshf[WIDTH]) begin
              r_t    <= rshf[WIDTH-1:0];
              r_n[0] <= 1'b1;
            end
            r_step <= r_step + 4'd1;
            r_state <= w_lastStep ? S_FIN : S_DIV_SH;
          end
          S_DZ: begin
            r_resHi <= r_n;
            r_resLo <= '1;
            r_dz    <= 1'b1;
            r_state <= S_FIN;
          end
          S_FIN: begin
            if (!r_dz) begin
              r_resHi <= r_t;
              r_resLo <= r_n;
            end
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign res_hi = r_resHi;
  assign res_lo = r_resLo;
  assign dz     = r_dz;
  assign op_alu = w_opAlu;
  assign op_shf = w_opShf;
  assign t      = r_t;
  assign aopy   = r_m;
  assign carry  = 1'b0;
  assign n15    = r_n[WIDTH-1];
  assign n0     = r_n[0];

endmodule
